serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 37 +++
 rtl/serial_addsub.sv | 152 +++++++++++++++
 tb/tb_serial_addsub.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub.
// The Zero flag is present only when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic             Zero;

  modport master (
    output Start, Sub, A, B, Cin,
    input  Busy, Done, Sum, Cout, Ovf, Zero
  );
  modport slave (
    input  Start, Sub, A, B, Cin,
    output Busy, Done, Sum, Cout, Ovf, Zero
  );
`else
  modport master (
    output Start, Sub, A, B, Cin,
    input  Busy, Done, Sum, Cout, Ovf
  );
  modport slave (
    input  Start, Sub, A, B, Cin,
    output Busy, Done, Sum, Cout, Ovf
  );
`endif
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, DIGIT bits per clock LSB first, Start/Busy/Done handshake.
// Optional Zero result flag enabled by SERIAL_ADDSUB_ZERO_FLAG_EN.
// state | meaning
// IDLE  | waiting for Start; Sum/Cout/Ovf hold the last result
// RUN   | one digit per clock; result lands on step STEPS-1
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  serial_addsub_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic             busy;
  logic             accept;
  logic             last_step;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    accept    = (state_q == IDLE) && bus.Start;
    last_step = (state_q == RUN) && (cnt_q == CW'(STEPS - 1));
  end

  // Digit ripple; dig_cmsb is the carry into the digit's top bit, which on the
  // final step is the carry into bit WIDTH-1 needed for overflow.
  always_comb begin
    logic carry;
    carry    = c_q;
    dig_cmsb = c_q;
    dig_sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) dig_cmsb = carry;
      dig_sum[i] = a_sr_q[i] ^ b_sr_q[i] ^ carry;
      carry      = (a_sr_q[i] & b_sr_q[i]) | (carry & (a_sr_q[i] ^ b_sr_q[i]));
    end
    dig_cout = carry;
  end

  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    c_d    = c_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    zero_d = zero_q;
`endif
    if (accept) begin
      a_sr_d = bus.A;
      b_sr_d = bus.Sub ? ~bus.B : bus.B;
      c_d    = bus.Sub | bus.Cin;
      cnt_d  = '0;
      res_d  = '0;
    end else if (busy) begin
      a_sr_d = a_sr_q >> DIGIT;
      b_sr_d = b_sr_q >> DIGIT;
      res_d  = res_q >> DIGIT;
      res_d[WIDTH-1 -: DIGIT] = dig_sum;
      c_d    = dig_cout;
      cnt_d  = cnt_q + 1'b1;
      if (last_step) begin
        sum_d  = res_d;
        cout_d = dig_cout;
        ovf_d  = dig_cmsb ^ dig_cout;
        done_d = 1'b1;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        zero_d = (res_d == '0);
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      zero_q <= 1'b0;
`endif
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      zero_q <= zero_d;
`endif
    end
  end

  assign bus.Busy = busy;
  assign bus.Done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.Ovf  = ovf_q;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
  assign bus.Zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized bench for serial_addsub in three shapes (8/1, 8/4, 4/4) against an arithmetic model.
// Zero flag is checked when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if81 ();
  serial_addsub_if #(.WIDTH(8)) if84 ();
  serial_addsub_if #(.WIDTH(4)) if44 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u81 (.Clk(clk), .Reset(rst), .bus(if81.slave));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u84 (.Clk(clk), .Reset(rst), .bus(if84.slave));
  serial_addsub #(.WIDTH(4), .DIGIT(4)) u44 (.Clk(clk), .Reset(rst), .bus(if44.slave));

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       zero;
    logic       cout;
    logic       ovf;
    logic [7:0] sum;
  } obs_t;

  typedef struct packed {
    logic       zero;
    logic       cout;
    logic       ovf;
    logic [7:0] sum;
  } res_t;

  int   wid   [3] = '{8, 8, 4};
  int   steps [3] = '{8, 2, 1};
  res_t last  [3];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int w, input logic st, input logic sub,
                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    case (w)
      0: begin if81.Start = st; if81.Sub = sub; if81.A = a; if81.B = b; if81.Cin = cin; end
      1: begin if84.Start = st; if84.Sub = sub; if84.A = a; if84.B = b; if84.Cin = cin; end
      default: begin
        if44.Start = st; if44.Sub = sub; if44.A = a[3:0]; if44.B = b[3:0]; if44.Cin = cin;
      end
    endcase
  endtask

  function automatic obs_t obs(input int w);
    obs_t o;
    o = '0;
    case (w)
      0: begin
        o.busy = if81.Busy; o.done = if81.Done; o.sum = if81.Sum;
        o.cout = if81.Cout; o.ovf = if81.Ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        o.zero = if81.Zero;
`endif
      end
      1: begin
        o.busy = if84.Busy; o.done = if84.Done; o.sum = if84.Sum;
        o.cout = if84.Cout; o.ovf = if84.Ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        o.zero = if84.Zero;
`endif
      end
      default: begin
        o.busy = if44.Busy; o.done = if44.Done; o.sum = {4'h0, if44.Sum};
        o.cout = if44.Cout; o.ovf = if44.Ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        o.zero = if44.Zero;
`endif
      end
    endcase
    return o;
  endfunction

  // Reference: plain integer arithmetic on W-bit operands.
  function automatic res_t model(input int w, input logic sub, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
    res_t r;
    int mask, aa, bb, full, s, msb;
    mask   = (1 << wid[w]) - 1;
    msb    = wid[w] - 1;
    aa     = int'(a) & mask;
    bb     = sub ? (~int'(b)) & mask : int'(b) & mask;
    full   = aa + bb + (sub ? 1 : int'(cin));
    s      = full & mask;
    r.sum  = 8'(s);
    r.cout = ((full >> wid[w]) & 1) != 0;
    r.ovf  = (aa[msb] == bb[msb]) && (s[msb] != aa[msb]);
    r.zero = (s == 0);
    return r;
  endfunction

  task automatic compare_res(input string tag, input obs_t o, input res_t e);
    check({tag, "/sum"},  32'(o.sum), 32'(e.sum));
    check({tag, "/cout"}, 32'(o.cout), 32'(e.cout));
    check({tag, "/ovf"},  32'(o.ovf), 32'(e.ovf));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    check({tag, "/zero"}, 32'(o.zero), 32'(e.zero));
`endif
  endtask

  // poke: 0 = Start low while busy, 1 = random Start/operands, 2 = Start with AA/55 at cycle 2
  task automatic do_op(input int w, input logic sub, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input int poke, input string tag);
    obs_t o;
    res_t e;
    int   n;
    bit   ok_busy, ok_hold;
    logic st;
    e = model(w, sub, a, b, cin);
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    drive(w, 1'b1, sub, a, b, cin);
    @(negedge clk);
    o = obs(w);
    check({tag, "/busy_start"}, 32'(o.busy), 32'd1);
    n = 0;
    while (n < steps[w] + 4) begin
      if (poke == 1)      drive(w, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      else if (poke == 2) drive(w, n == 2, 1'b0, 8'hAA, 8'h55, 1'b0);
      else                drive(w, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk);
      n++;
      o = obs(w);
      if (o.done) break;
      if (!o.busy) ok_busy = 1'b0;
      if (o.sum !== last[w].sum || o.cout !== last[w].cout || o.ovf !== last[w].ovf) ok_hold = 1'b0;
    end
    st = 1'b0;
    drive(w, st, 1'b0, 8'h00, 8'h00, 1'b0);
    check({tag, "/latency"}, 32'(n), 32'(steps[w]));
    check({tag, "/busy_run"}, 32'(ok_busy), 32'd1);
    check({tag, "/hold"}, 32'(ok_hold), 32'd1);
    check({tag, "/busy_done"}, 32'(o.busy), 32'd0);
    compare_res(tag, o, e);
    last[w] = e;
  endtask

  task automatic idle(input int w, input int k, input string tag);
    obs_t o;
    bit   ok;
    ok = 1'b1;
    drive(w, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (k) begin
      @(negedge clk);
      o = obs(w);
      if (o.done || o.busy) ok = 1'b0;
    end
    check({tag, "/idle"}, 32'(ok), 32'd1);
  endtask

  initial begin
    obs_t o;
    res_t zero_r;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    zero_r = '0;
    for (int w = 0; w < 3; w++) begin
      last[w] = zero_r;
      o = obs(w);
      check("rst/busy", 32'(o.busy), 32'd0);
      check("rst/done", 32'(o.done), 32'd0);
      compare_res("rst", o, zero_r);
    end

    do_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    idle(0, 2, "after_ff");
    do_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
    do_op(0, 1'b0, 8'h10, 8'h20, 1'b1, 0, "b2b_10_20");
    idle(0, 1, "after_b2b");
    do_op(0, 1'b1, 8'h05, 8'h07, 1'b0, 0, "sub_05_07");
    idle(0, 1, "after_sub1");
    do_op(0, 1'b1, 8'h80, 8'h01, 1'b1, 0, "sub_80_01");
    idle(0, 1, "after_sub2");
    do_op(0, 1'b0, 8'h12, 8'h34, 1'b0, 2, "ignore_start");
    idle(0, 1, "after_ignore");

    // Reset during cycle 4 of an operation discards it
    drive(0, 1'b1, 1'b0, 8'h55, 8'h22, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = obs(0);
    check("midrst/busy", 32'(o.busy), 32'd0);
    check("midrst/done", 32'(o.done), 32'd0);
    compare_res("midrst", o, zero_r);
    last[0] = zero_r;
    last[1] = zero_r;
    last[2] = zero_r;
    idle(0, 10, "midrst_nodone");

    do_op(1, 1'b0, 8'h3C, 8'h0F, 1'b1, 0, "d4_3c_0f");
    idle(1, 1, "after_d4");
    do_op(2, 1'b0, 8'h08, 8'h08, 1'b0, 0, "w4_8_8");
    idle(2, 1, "after_w4");

    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(1, 0) == 0) idle(w, $urandom_range(2, 1), "rnd_gap");
        do_op(w, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              int'($urandom_range(1, 0)), "rnd");
      end
      idle(w, 2, "rnd_end");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
